p4_router_egress_port_adapt: RTL and testbench
==============================================

Name: p4_router_egress_port_adapt

Overview:
Egress-side counterpart of the router ingress port adaptation: takes frames from the wide converged bus and presents them on a narrower physical egress port.
- Single clock; store-and-forward frame buffer with drop-on-full, so the router core never sees backpressure from a port.
- Down-converts each stored word into OUT_DATA_BYTES chunks, with correct tkeep and tlast.
- One instance per egress physical port.

Parameters:
- IN_DATA_BYTES, 64: converged-bus width in bytes. Must be a multiple of OUT_DATA_BYTES.
- OUT_DATA_BYTES, 8: physical-port width in bytes. Power of two, at least 1.
- DEPTH_WORDS, 64: buffer depth in IN-width words. Power of two, at least 2*ceil(MTU_BYTES/IN_DATA_BYTES).
- MTU_BYTES, 1500: largest frame accepted. Larger frames are dropped.

Ports:
- clk, in, 1: the block's single clock.
- aresetn, in, 1: asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronised to clk externally.
- s_axis_tvalid, in, 1: converged-bus beat valid.
- s_axis_tready, out, 1: always 1 out of reset (feed-forward input side).
- s_axis_tdata, in, IN_DATA_BYTES*8: beat data, byte 0 in bits [7:0].
- s_axis_tkeep, in, IN_DATA_BYTES: byte enables. Contiguous from LSB.
- s_axis_tlast, in, 1: end of frame.
- m_axis_tvalid, out, 1: physical-port beat valid.
- m_axis_tready, in, 1: physical-port ready.
- m_axis_tdata, out, OUT_DATA_BYTES*8: output chunk.
- m_axis_tkeep, out, OUT_DATA_BYTES: output byte enables.
- m_axis_tlast, out, 1: last chunk of frame.
- drop_pulse, out, 1: one-cycle pulse on the input tlast of a dropped frame.
- drop_count, out, 32: saturating count of dropped frames.
- frame_count, out, 32: wrapping count of frames completed on m_axis.

Behaviour:
Reset values:
- s_axis_tready=0 while in reset, 1 otherwise.
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep=0.
- drop_pulse=0, drop_count=0, frame_count=0.
- All pointers 0. Any partial or stored frames are discarded.

Write side (per accepted beat, i.e. s_axis_tvalid and s_axis_tready both high):
- Word written to RAM at wr_ptr_cur; wr_ptr_cur increments.
- Per-frame byte count accumulated.
- On tlast with no error: wr_ptr_commit <= wr_ptr_cur + 1. The frame becomes visible to the read side the next cycle.

Drop conditions (set a sticky frame_err flag):
- Buffer full: (wr_ptr_cur - rd_ptr) == DEPTH_WORDS when a beat arrives. That beat is not written.
- Byte count exceeds MTU_BYTES.
- A non-tlast beat with tkeep not all-ones.
- tkeep == 0 on any beat.

While frame_err is set:
- Remaining beats are accepted but not written.
- On tlast: wr_ptr_cur <= wr_ptr_commit, drop_pulse=1 for one cycle, drop_count increments (saturating at 2^32-1), frame_err clears.
- A tlast beat that itself triggers an error is dropped in the same cycle.

Pointers:
- All pointers are log2(DEPTH_WORDS)+1 bits; the extra MSB distinguishes full from empty, and wrap-around is natural.
- Empty: rd_ptr == wr_ptr_commit.
- Committed frames are never overwritten.

Read FSM:
- IDLE: if not empty, issue RAM read at rd_ptr, go to LOAD.
- LOAD: RAM output (1-cycle read latency) registered into word_reg with its keep and last; rd_ptr++; chunk_idx=0; go to SER.
- SER: present chunk chunk_idx. tvalid=1; tkeep is the chunk's slice of the keep.
  - tlast=1 when the word is a last word and the next chunk's keep is 0, or this is the final chunk.
  - On tready: if this was the word's final non-empty chunk, go to LOAD (prefetch issued if not empty) or IDLE. Otherwise chunk_idx++.
- Chunks with all-zero keep are never emitted.
- AXIS hold rule: while tvalid=1 and tready=0, tdata/tkeep/tlast are stable.

Timing and ordering:
- Latency: first m_axis beat is valid 3 cycles after the input tlast beat is accepted, with the buffer empty.
- Throughput: 1 chunk/cycle within a word. One bubble between words is permitted.
- frame_count increments on each accepted chunk that has tlast set.
- Simultaneous commit and read-empty: the read side sees the new frame on the following cycle.
- A drop never disturbs the in-progress read.

Decomposition:
- Package p4_router_pkg:
  - function clog2-based PTR_W(DEPTH_WORDS);
  - localparam RATIO = IN_DATA_BYTES/OUT_DATA_BYTES;
  - enum rd_state_t {IDLE, LOAD, SER}.
- RAM: inferred simple dual-port in the top module.
- Sub-module p4_router_egress_width_serializer: word_reg plus the SER chunking logic, with a valid/ready word input and the m_axis output.

Test Plan:
1. IN=64, OUT=8: one 130-byte frame (beats keep 64'hFF..FF, 64'hFF..FF, 64'h3), tready=1 -> 17 output beats; beats 1-16 tkeep=8'hFF, beat 17 tkeep=8'h03 with tlast; first tvalid 3 cycles after input tlast; frame_count=1.
2. Same frame with m_axis_tready toggled 1/0 every cycle -> identical byte sequence, data held stable across stall cycles, no loss.
3. DEPTH_WORDS=64, tready=0, three back-to-back 24-word frames -> frames 1-2 stored; frame 3 hits full at word 17 -> drop_pulse one cycle at its tlast, drop_count=1; release tready -> frames 1-2 output intact.
4. 1600-byte frame (MTU 1500), then a 64-byte frame -> first dropped (drop_count=1), second output as 8 full chunks with tlast.
5. Frame whose beat 1 (non-last) has tkeep=64'h0F..FF -> dropped, drop_count=1; next valid frame passes.
6. aresetn asserted mid-serialization of chunk 5 -> m_axis_tvalid=0 immediately, counters 0; after release, a new 16-byte frame outputs exactly 2 chunks with nothing from the old frame.

Source files
------------

// File: rtl/p4_router_pkg.sv
// Shared types and helpers for the router egress port adaptation.
// Holds the read FSM state type, pointer width and width ratio helpers.
package p4_router_pkg;

  localparam int DEF_IN_BYTES  = 64;
  localparam int DEF_OUT_BYTES = 8;
  localparam int RATIO = DEF_IN_BYTES / DEF_OUT_BYTES;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SER
  } rd_state_t;

  // Extra MSB separates full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ratio(input int ib, input int ob);
    return ib / ob;
  endfunction

endpackage

// File: rtl/p4_router_egress_width_serializer.sv
// Holds one wide word and emits it as OUT_BYTES chunks on AXIS.
// Ports: word in (valid/ready, data, keep, last), m_axis out, word_done.
module p4_router_egress_width_serializer
  import p4_router_pkg::*;
#(
  parameter int IN_BYTES  = 64,
  parameter int OUT_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_word_valid,
  output logic                   o_word_ready,
  input  logic [IN_BYTES*8-1:0]  i_word_data,
  input  logic [IN_BYTES-1:0]    i_word_keep,
  input  logic                   i_word_last,
  output logic                   o_tvalid,
  input  logic                   i_tready,
  output logic [OUT_BYTES*8-1:0] o_tdata,
  output logic [OUT_BYTES-1:0]   o_tkeep,
  output logic                   o_tlast,
  output logic                   o_word_done
);

  localparam int CHUNKS = ratio(IN_BYTES, OUT_BYTES);
  localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

  logic                  r_full;
  logic [IN_BYTES*8-1:0] r_data;
  logic [IN_BYTES-1:0]   r_keep;
  logic                  r_last;
  logic [IW-1:0]         r_idx;

  logic [IN_BYTES*8-1:0] w_dsh;
  logic [IN_BYTES-1:0]   w_ksh;
  logic                  w_final;

  assign w_dsh = r_data >> (8 * OUT_BYTES * int'(r_idx));
  assign w_ksh = r_keep >> (OUT_BYTES * int'(r_idx));
  // Keep is contiguous, so an empty next chunk means nothing follows.
  assign w_final = (r_idx == LAST_IDX) ||
                   ((w_ksh >> OUT_BYTES) == '0);

  assign o_word_ready = ~r_full;
  assign o_tvalid     = r_full;
  assign o_tdata      = r_full ? w_dsh[OUT_BYTES*8-1:0] : '0;
  assign o_tkeep      = r_full ? w_ksh[OUT_BYTES-1:0] : '0;
  assign o_tlast      = r_full & r_last & w_final;
  assign o_word_done  = r_full & i_tready & w_final;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_keep <= '0;
      r_last <= 1'b0;
      r_idx  <= '0;
    end else if (i_word_valid && !r_full) begin
      r_full <= 1'b1;
      r_data <= i_word_data;
      r_keep <= i_word_keep;
      r_last <= i_word_last;
      r_idx  <= '0;
    end else if (o_word_done) begin
      r_full <= 1'b0;
    end else if (r_full && i_tready) begin
      r_idx <= r_idx + IW'(1);
    end
  end

endmodule

// File: rtl/p4_router_egress_port_adapt.sv
// Egress port adapter: store-and-forward buffer with drop-on-full,
// down-converting wide converged-bus words to the physical port width.
// Ports: s_axis (wide in), m_axis (narrow out), drop_pulse/drop_count,
// frame_count.
module p4_router_egress_port_adapt
  import p4_router_pkg::*;
#(
  parameter int IN_DATA_BYTES  = 64,
  parameter int OUT_DATA_BYTES = 8,
  parameter int DEPTH_WORDS    = 64,
  parameter int MTU_BYTES      = 1500
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [IN_DATA_BYTES*8-1:0]  s_axis_tdata,
  input  logic [IN_DATA_BYTES-1:0]    s_axis_tkeep,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [OUT_DATA_BYTES*8-1:0] m_axis_tdata,
  output logic [OUT_DATA_BYTES-1:0]   m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic                        drop_pulse,
  output logic [31:0]                 drop_count,
  output logic [31:0]                 frame_count
);

  localparam int PW = ptr_w(DEPTH_WORDS);
  localparam int AW = PW - 1;
  localparam int IB = IN_DATA_BYTES;
  localparam int WW = IB * 9 + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH_WORDS);

  logic [WW-1:0] mem [DEPTH_WORDS];
  logic [WW-1:0] r_ram_q;

  logic [PW-1:0] r_wr_cur;
  logic [PW-1:0] r_wr_commit;
  logic [PW-1:0] r_rd_ptr;
  logic          r_err;
  logic [31:0]   r_bcnt;
  logic          r_rdy;
  logic          r_drop_pulse;
  logic [31:0]   r_drop_cnt;
  logic [31:0]   r_frame_cnt;
  rd_state_t     r_state;
  rd_state_t     w_state_nx;

  logic [31:0] w_nbytes;
  logic [31:0] w_bcnt_nx;
  logic        w_beat;
  logic        w_full;
  logic        w_bad;
  logic        w_err;
  logic        w_wr;
  logic        w_empty;
  logic        w_rd_en;
  logic        w_wvalid;
  logic        w_word_ready;
  logic        w_word_done;

  always_comb begin
    w_nbytes = '0;
    for (int i = 0; i < IB; i++)
      w_nbytes = w_nbytes + 32'(s_axis_tkeep[i]);
  end

  assign w_beat    = s_axis_tvalid & r_rdy;
  assign w_full    = (r_wr_cur - r_rd_ptr) == DEPTH_P;
  assign w_bcnt_nx = r_bcnt + w_nbytes;
  assign w_bad     = w_full
                   | (w_bcnt_nx > 32'(MTU_BYTES))
                   | (~s_axis_tlast & ~&s_axis_tkeep)
                   | (s_axis_tkeep == '0);
  assign w_err     = r_err | w_bad;
  assign w_wr      = w_beat & ~w_err;
  assign w_empty   = r_rd_ptr == r_wr_commit;

  always_ff @(posedge clk) begin
    if (w_wr)
      mem[r_wr_cur[AW-1:0]] <=
        {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    if (w_rd_en)
      r_ram_q <= mem[r_rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_cur     <= '0;
      r_wr_commit  <= '0;
      r_err        <= 1'b0;
      r_bcnt       <= '0;
      r_rdy        <= 1'b0;
      r_drop_pulse <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_rdy        <= 1'b1;
      r_drop_pulse <= 1'b0;
      if (w_beat) begin
        if (s_axis_tlast) begin
          r_bcnt <= '0;
          r_err  <= 1'b0;
          if (w_err) begin
            // Rewind over any words this frame already wrote.
            r_wr_cur     <= r_wr_commit;
            r_drop_pulse <= 1'b1;
            if (r_drop_cnt != '1)
              r_drop_cnt <= r_drop_cnt + 32'd1;
          end else begin
            r_wr_cur    <= r_wr_cur + PW'(1);
            r_wr_commit <= r_wr_cur + PW'(1);
          end
        end else begin
          r_bcnt <= w_bcnt_nx;
          r_err  <= w_err;
          if (!w_err)
            r_wr_cur <= r_wr_cur + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_rd_ptr    <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_wvalid)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
        r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_rd_en    = 1'b0;
    w_wvalid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_rd_en    = 1'b1;
          w_state_nx = LOAD;
        end
      end
      LOAD: begin
        if (w_word_ready) begin
          w_wvalid   = 1'b1;
          w_state_nx = SER;
        end
      end
      SER: begin
        if (w_word_done) begin
          if (!w_empty) begin
            w_rd_en    = 1'b1;
            w_state_nx = LOAD;
          end else begin
            w_state_nx = IDLE;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  p4_router_egress_width_serializer #(
    .IN_BYTES  (IN_DATA_BYTES),
    .OUT_BYTES (OUT_DATA_BYTES)
  ) u_ser (
    .clk          (clk),
    .rst_n        (aresetn),
    .i_word_valid (w_wvalid),
    .o_word_ready (w_word_ready),
    .i_word_data  (r_ram_q[IB*8-1:0]),
    .i_word_keep  (r_ram_q[IB*9-1:IB*8]),
    .i_word_last  (r_ram_q[WW-1]),
    .o_tvalid     (m_axis_tvalid),
    .i_tready     (m_axis_tready),
    .o_tdata      (m_axis_tdata),
    .o_tkeep      (m_axis_tkeep),
    .o_tlast      (m_axis_tlast),
    .o_word_done  (w_word_done)
  );

  assign s_axis_tready = r_rdy;
  assign drop_pulse    = r_drop_pulse;
  assign drop_count    = r_drop_cnt;
  assign frame_count   = r_frame_cnt;

endmodule

// File: tb/tb_p4_router_egress_port_adapt.sv
// Self-checking bench for p4_router_egress_port_adapt.
// Byte-queue reference model; random data, lengths and stalls.
module tb_p4_router_egress_port_adapt;

  localparam int IB  = 64;
  localparam int OB  = 8;
  localparam int DW  = 64;
  localparam int MTU = 1500;

  logic            clk = 1'b0;
  logic            aresetn;
  logic            s_tvalid;
  logic            s_tready;
  logic [IB*8-1:0] s_tdata;
  logic [IB-1:0]   s_tkeep;
  logic            s_tlast;
  logic            m_tvalid;
  logic            m_tready = 1'b0;
  logic [OB*8-1:0] m_tdata;
  logic [OB-1:0]   m_tkeep;
  logic            m_tlast;
  logic            drop_pulse;
  logic [31:0]     drop_count;
  logic [31:0]     frame_count;

  always #5 clk = ~clk;

  p4_router_egress_port_adapt #(
    .IN_DATA_BYTES  (IB),
    .OUT_DATA_BYTES (OB),
    .DEPTH_WORDS    (DW),
    .MTU_BYTES      (MTU)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .drop_pulse    (drop_pulse),
    .drop_count    (drop_count),
    .frame_count   (frame_count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] q_exp[$];
  int         q_len[$];
  int         rem = 0;
  int         n_acc = 0;
  int         exp_frames = 0;
  int         exp_drops = 0;
  int         tr_mode = 0;

  always @(posedge clk) begin
    #1;
    case (tr_mode)
      0: m_tready = 1'b1;
      1: m_tready = ~m_tready;
      2: m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b0;
    endcase
  end

  logic            hold_v = 1'b0;
  logic [63:0]     hold_d;
  logic [OB-1:0]   hold_k;
  logic            hold_l;
  int              mn;
  logic [63:0]     ek, ed, md;

  always @(negedge clk) begin
    if (!aresetn) begin
      q_exp.delete();
      q_len.delete();
      rem = 0;
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(m_tvalid), 1);
        chk("hold_data", m_tdata, hold_d);
        chk("hold_keep", 64'(m_tkeep), 64'(hold_k));
        chk("hold_last", 64'(m_tlast), 64'(hold_l));
      end
      hold_v = m_tvalid && !m_tready;
      hold_d = m_tdata;
      hold_k = m_tkeep;
      hold_l = m_tlast;
      if (m_tvalid && m_tready) begin
        n_acc++;
        if (rem == 0 && q_len.size() > 0)
          rem = q_len.pop_front();
        if (rem == 0) begin
          chk("extra_chunk", 64'(m_tvalid), 0);
        end else begin
          mn = (rem > OB) ? OB : rem;
          ek = '0; ed = '0; md = '0;
          for (int i = 0; i < mn; i++) begin
            ek[i] = 1'b1;
            md[i*8 +: 8] = 8'hFF;
            ed[i*8 +: 8] = q_exp.pop_front();
          end
          chk("chunk_keep", 64'(m_tkeep), ek);
          chk("chunk_last", 64'(m_tlast), 64'(rem == mn));
          chk("chunk_data", m_tdata & md, ed);
          rem -= mn;
        end
      end
    end
  end

  // Drives one frame beat-per-cycle; the model keeps it only if legal.
  task automatic send_frame(input int nbytes, input int bad,
                            input bit force_drop);
    int nb;
    int n;
    bit drop;
    logic [7:0] fb[$];
    nb = (nbytes + IB - 1) / IB;
    drop = force_drop || (nbytes > MTU) || (bad >= 0);
    for (int i = 0; i < nbytes; i++)
      fb.push_back(8'($urandom));
    for (int b = 0; b < nb; b++) begin
      n = (b == nb - 1) ? nbytes - b * IB : IB;
      s_tdata = '0;
      s_tkeep = '0;
      for (int i = 0; i < n; i++) begin
        s_tkeep[i] = 1'b1;
        s_tdata[i*8 +: 8] = fb[b*IB + i];
      end
      if (b == bad)
        s_tkeep = (b == nb - 1) ? '0 : {4'h0, {(IB-4){1'b1}}};
      s_tlast  = (b == nb - 1);
      s_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk("drop_pulse", 64'(drop_pulse), 64'(drop));
    if (drop) begin
      exp_drops++;
    end else begin
      exp_frames++;
      foreach (fb[i]) q_exp.push_back(fb[i]);
      q_len.push_back(nbytes);
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((q_len.size() != 0 || rem != 0) && k < 20000) begin
      @(posedge clk);
      k++;
    end
    chk("drain_timeout", 64'(k < 20000), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int k;
  int base;
  int len;
  int bad;

  initial begin
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", 64'(s_tready), 0);
    chk("rst_m_tvalid", 64'(m_tvalid), 0);
    chk("rst_m_tlast", 64'(m_tlast), 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tkeep", 64'(m_tkeep), 0);
    chk("rst_drop_pulse", 64'(drop_pulse), 0);
    chk("rst_drop_count", 64'(drop_count), 0);
    chk("rst_frame_count", 64'(frame_count), 0);
    aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("s_tready", 64'(s_tready), 1);

    tr_mode = 0;
    send_frame(130, -1, 0);
    k = 0;
    while (!m_tvalid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency_cycles", 64'(k + 1), 3);
    wait_drain();
    chk("t1_frame_count", 64'(frame_count), 64'(exp_frames));

    tr_mode = 1;
    send_frame(130, -1, 0);
    wait_drain();
    chk("t2_frame_count", 64'(frame_count), 64'(exp_frames));

    tr_mode = 3;
    send_frame(23 * IB, -1, 0);
    send_frame(23 * IB, -1, 0);
    send_frame(23 * IB, -1, 1);
    chk("t3_drop_count", 64'(drop_count), 64'(exp_drops));
    tr_mode = 0;
    wait_drain();
    chk("t3_frame_count", 64'(frame_count), 64'(exp_frames));

    send_frame(1600, -1, 0);
    send_frame(64, -1, 0);
    wait_drain();
    chk("t4_drop_count", 64'(drop_count), 64'(exp_drops));
    chk("t4_frame_count", 64'(frame_count), 64'(exp_frames));

    send_frame(192, 1, 0);
    send_frame(100, -1, 0);
    send_frame(70, 1, 0);
    send_frame(64, -1, 0);
    wait_drain();
    chk("t5_drop_count", 64'(drop_count), 64'(exp_drops));
    chk("t5_frame_count", 64'(frame_count), 64'(exp_frames));

    for (int r = 0; r < 24; r++) begin
      len = $urandom_range(1, 400);
      bad = ($urandom_range(0, 7) == 0) ?
            $urandom_range(0, (len - 1) / IB) : -1;
      tr_mode = $urandom_range(0, 2);
      send_frame(len, bad, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if (r % 4 == 3) wait_drain();
    end
    tr_mode = 0;
    wait_drain();
    chk("rnd_drop_count", 64'(drop_count), 64'(exp_drops));
    chk("rnd_frame_count", 64'(frame_count), 64'(exp_frames));

    base = n_acc;
    send_frame(64, -1, 0);
    k = 0;
    while (n_acc - base < 4 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("t6_chunk5_valid", 64'(m_tvalid), 1);
    aresetn = 1'b0;
    #1;
    exp_frames = 0;
    exp_drops  = 0;
    chk("t6_rst_tvalid", 64'(m_tvalid), 0);
    chk("t6_rst_frame_count", 64'(frame_count), 64'(exp_frames));
    chk("t6_rst_drop_count", 64'(drop_count), 64'(exp_drops));
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    base = n_acc;
    send_frame(16, -1, 0);
    wait_drain();
    chk("t6_chunks", 64'(n_acc - base), 2);
    chk("t6_frame_count", 64'(frame_count), 64'(exp_frames));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
